// File: rtl/iir_stuff_sequencer_if.sv
// ---------------------------------------------------------------------------
// iir_stuff_sequencer_if
// Groups every handshake and data signal that the IIR stuffing sequencer
// exchanges with its stream source, its config master and the iir_filter
// datapath.
//   slave  : the sequencer's view (accepts samples/config, drives the filter)
//   master : the surrounding environment's view (source, config, filter y)
// All data words are two's complement and are passed bit-exact.
// Handshake rule for both s_* and cfg_*: a transfer happens on a rising clock
// edge where valid and ready are both 1; ready never depends on valid, and a
// source that is not accepted must hold its valid/data until it is.
// ---------------------------------------------------------------------------
interface iir_stuff_sequencer_if #(
  parameter int WORD_LEN_IN   = 17,
  parameter int WORD_LEN_OUT  = 17,
  parameter int WORD_LEN_COEF = 17
);
  logic                     s_valid;
  logic                     s_ready;
  logic [WORD_LEN_IN-1:0]   s_x;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_addr;
  logic [WORD_LEN_COEF-1:0] cfg_data;
  logic [WORD_LEN_IN-1:0]   f_x;
  logic [WORD_LEN_COEF-1:0] f_a1;
  logic [WORD_LEN_COEF-1:0] f_b0;
  logic [WORD_LEN_COEF-1:0] f_b1;
  logic                     flt_reset;
  logic [WORD_LEN_OUT-1:0]  f_y;
  logic                     m_valid;
  logic [WORD_LEN_OUT-1:0]  m_y;

  modport slave (
    input  s_valid, s_x, cfg_valid, cfg_addr, cfg_data, f_y,
    output s_ready, cfg_ready, f_x, f_a1, f_b0, f_b1, flt_reset, m_valid, m_y
  );

  modport master (
    output s_valid, s_x, cfg_valid, cfg_addr, cfg_data, f_y,
    input  s_ready, cfg_ready, f_x, f_a1, f_b0, f_b1, flt_reset, m_valid, m_y
  );
endinterface

// File: rtl/iir_stuff_sequencer.sv
// ---------------------------------------------------------------------------
// iir_stuff_sequencer
// Feeds a free-running single-stage IIR filter from a sparse sample stream.
// Every clock the filter gets either an accepted sample or a zero stuff; a tag
// travels alongside each real sample so that exactly the matching filter
// outputs are presented on m_valid/m_y. Coefficients are written into shadow
// registers and committed atomically once all tagged samples have left the
// pipe, after which the filter is held in reset for FLUSH_CYCLES clocks.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high
//   bus         iir_stuff_sequencer_if.slave (stream in, config, filter, out)
//   dbg_state_o current FSM state (0 RUN, 1 DRAIN, 2 FLUSH)
// ---------------------------------------------------------------------------
module iir_stuff_sequencer #(
  parameter int WORD_LEN_IN   = 17,
  parameter int WORD_LEN_OUT  = 17,
  parameter int WORD_LEN_COEF = 17,
  parameter int LATENCY       = 2,
  parameter int FLUSH_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  iir_stuff_sequencer_if.slave        bus,
  output logic [1:0]                  dbg_state_o
);
  localparam int IFW = $clog2(LATENCY + 2);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [FCW-1:0]           flush_cnt_q, flush_cnt_d;
  logic [LATENCY:0]         tag_q, tag_d;
  logic [IFW-1:0]           inflight_q, inflight_d;
  logic [WORD_LEN_IN-1:0]   f_x_q, f_x_d;
  logic [WORD_LEN_COEF-1:0] sh_a1_q, sh_a1_d, sh_b0_q, sh_b0_d, sh_b1_q, sh_b1_d;
  logic [WORD_LEN_COEF-1:0] act_a1_q, act_a1_d, act_b0_q, act_b0_d, act_b1_q, act_b1_d;
  logic [WORD_LEN_OUT-1:0]  m_y_q, m_y_d;
  logic                     m_valid_q, m_valid_d;

  logic accept, cfg_fire, tag_exit, run_st;

  // Ready is withheld while reset is asserted so the source sees no
  // acceptance window until the block is actually running.
  assign run_st        = (state_q == ST_RUN) && !reset;
  assign bus.s_ready   = run_st;
  assign bus.cfg_ready = run_st;
  assign bus.flt_reset = reset || (state_q == ST_FLUSH);
  assign bus.f_x       = f_x_q;
  assign bus.f_a1      = act_a1_q;
  assign bus.f_b0      = act_b0_q;
  assign bus.f_b1      = act_b1_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_y       = m_y_q;
  assign dbg_state_o   = state_q;

  assign accept   = bus.s_valid && run_st;
  assign cfg_fire = bus.cfg_valid && run_st;
  // The tag at the last stage marks the cycle whose f_y belongs to a sample.
  assign tag_exit = tag_q[LATENCY];

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tag_d       = {tag_q[LATENCY-1:0], accept};
    inflight_d  = inflight_q;
    f_x_d       = accept ? bus.s_x : '0;
    sh_a1_d     = sh_a1_q;
    sh_b0_d     = sh_b0_q;
    sh_b1_d     = sh_b1_q;
    act_a1_d    = act_a1_q;
    act_b0_d    = act_b0_q;
    act_b1_d    = act_b1_q;
    m_valid_d   = tag_exit;
    m_y_d       = tag_exit ? bus.f_y : m_y_q;

    // Entry and exit on the same edge cancel out.
    if (accept && !tag_exit) begin
      inflight_d = inflight_q + IFW'(1);
    end else if (!accept && tag_exit) begin
      inflight_d = inflight_q - IFW'(1);
    end

    if (cfg_fire) begin
      case (bus.cfg_addr)
        2'd0:    sh_a1_d = bus.cfg_data;
        2'd1:    sh_b0_d = bus.cfg_data;
        2'd2:    sh_b1_d = bus.cfg_data;
        default: sh_a1_d = sh_a1_q;
      endcase
    end

    case (state_q)
      ST_RUN: begin
        if (cfg_fire && (bus.cfg_addr == 2'd3)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Pipe empty: commit all three coefficients on the same edge.
        if (inflight_q == '0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
          act_a1_d    = sh_a1_q;
          act_b0_d    = sh_b0_q;
          act_b1_d    = sh_b1_q;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      f_x_q       <= '0;
      sh_a1_q     <= '0;
      sh_b0_q     <= '0;
      sh_b1_q     <= '0;
      act_a1_q    <= '0;
      act_b0_q    <= '0;
      act_b1_q    <= '0;
      m_y_q       <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      f_x_q       <= f_x_d;
      sh_a1_q     <= sh_a1_d;
      sh_b0_q     <= sh_b0_d;
      sh_b1_q     <= sh_b1_d;
      act_a1_q    <= act_a1_d;
      act_b0_q    <= act_b0_d;
      act_b1_q    <= act_b1_d;
      m_y_q       <= m_y_d;
      m_valid_q   <= m_valid_d;
    end
  end
endmodule

// File: tb/tb_iir_stuff_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iir_stuff_sequencer
// Directed bench for iir_stuff_sequencer. A stand-in filter delays f_x by
// LATENCY clocks and XORs a constant, so every tagged m_y identifies which
// sample (or stuff) it came from.
// ---------------------------------------------------------------------------
module tb_iir_stuff_sequencer;
  localparam int WI  = 17;
  localparam int WO  = 17;
  localparam int WC  = 17;
  localparam int LAT = 2;
  localparam int FLC = 4;
  localparam logic [16:0] K = 17'h12345;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  iir_stuff_sequencer_if #(.WORD_LEN_IN(WI), .WORD_LEN_OUT(WO), .WORD_LEN_COEF(WC)) bus ();

  iir_stuff_sequencer #(
    .WORD_LEN_IN(WI), .WORD_LEN_OUT(WO), .WORD_LEN_COEF(WC),
    .LATENCY(LAT), .FLUSH_CYCLES(FLC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // Stand-in filter: y = x delayed LATENCY clocks, XOR K.
  logic [16:0] d1, d2;
  always_ff @(posedge clk) begin
    if (bus.flt_reset) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= bus.f_x;
      d2 <= d1;
    end
  end
  assign bus.f_y = d2 ^ K;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid   = 1'b0;
    bus.s_x       = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_data  = '0;
  endtask

  task automatic cfg_wr(input logic [1:0] addr, input logic [16:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sv;
    logic [16:0] sx;
    logic        cv;
    logic [1:0]  ca;
    logic [16:0] cd;
    logic        rdy;
    logic [16:0] fx;
    logic        mv;
    logic [16:0] my;
    logic        flt;
    logic [16:0] a1;
    logic [16:0] b0;
    logic [16:0] b1;
  } vec_t;

  localparam int NV = 18;
  vec_t vec[NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [16:0] x;
    logic [16:0] prev_fy;
    int          pulses;

    idle_inputs();

    // Sparse stream (rows 0-7), shadow writes + commit on empty pipe (8-17).
    //            sv    sx         cv    ca    cd          rdy   fx         mv    my         flt   a1         b0         b1
    vec[0]  = '{1'b1, 17'h08000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[1]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h08000, 1'b0, 17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[2]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[3]  = '{1'b1, 17'h10000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[4]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h10000, 1'b1, 17'h1A345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[5]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h1A345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[6]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h1A345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[7]  = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b1, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[8]  = '{1'b0, 17'h00000, 1'b1, 2'd0, 17'h04000, 1'b1, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[9]  = '{1'b0, 17'h00000, 1'b1, 2'd1, 17'h08000, 1'b1, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[10] = '{1'b0, 17'h00000, 1'b1, 2'd2, 17'h02000, 1'b1, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[11] = '{1'b0, 17'h00000, 1'b1, 2'd3, 17'h1FFFF, 1'b1, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[12] = '{1'b1, 17'h0ABCD, 1'b0, 2'd0, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h00000, 17'h00000, 17'h00000};
    vec[13] = '{1'b1, 17'h0ABCD, 1'b0, 2'd0, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h02345, 1'b1, 17'h04000, 17'h08000, 17'h02000};
    vec[14] = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h02345, 1'b1, 17'h04000, 17'h08000, 17'h02000};
    vec[15] = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h02345, 1'b1, 17'h04000, 17'h08000, 17'h02000};
    vec[16] = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b0, 17'h00000, 1'b0, 17'h02345, 1'b1, 17'h04000, 17'h08000, 17'h02000};
    vec[17] = '{1'b0, 17'h00000, 1'b0, 2'd0, 17'h00000, 1'b1, 17'h00000, 1'b0, 17'h02345, 1'b0, 17'h04000, 17'h08000, 17'h02000};

    // ---------------- reset state ----------------
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst flt_reset", bus.flt_reset, 1'b1);
    chk("rst s_ready", bus.s_ready, 1'b0);
    chk("rst cfg_ready", bus.cfg_ready, 1'b0);
    chk("rst f_x", bus.f_x, 17'h0);
    chk("rst m_valid", bus.m_valid, 1'b0);
    chk("rst m_y", bus.m_y, 17'h0);
    chk("rst f_a1", bus.f_a1, 17'h0);
    chk("rst state", dbg_state, 2'd0);
    reset = 1'b0;

    // ---------------- table-driven rows ----------------
    for (int i = 0; i < NV; i++) begin
      bus.s_valid   = vec[i].sv;
      bus.s_x       = vec[i].sx;
      bus.cfg_valid = vec[i].cv;
      bus.cfg_addr  = vec[i].ca;
      bus.cfg_data  = vec[i].cd;
      #1;
      chk($sformatf("row%0d s_ready", i), bus.s_ready, vec[i].rdy);
      chk($sformatf("row%0d cfg_ready", i), bus.cfg_ready, vec[i].rdy);
      chk($sformatf("row%0d f_x", i), bus.f_x, vec[i].fx);
      chk($sformatf("row%0d m_valid", i), bus.m_valid, vec[i].mv);
      chk($sformatf("row%0d m_y", i), bus.m_y, vec[i].my);
      chk($sformatf("row%0d flt_reset", i), bus.flt_reset, vec[i].flt);
      chk($sformatf("row%0d f_a1", i), bus.f_a1, vec[i].a1);
      chk($sformatf("row%0d f_b0", i), bus.f_b0, vec[i].b0);
      chk($sformatf("row%0d f_b1", i), bus.f_b1, vec[i].b1);
      step();
    end
    idle_inputs();
    step();

    // ---------------- commit with two samples in flight ----------------
    cfg_wr(2'd0, 17'h1FFFF);
    cfg_wr(2'd1, 17'h10001);
    cfg_wr(2'd2, 17'h0AAAA);
    bus.s_valid = 1'b1;
    bus.s_x     = 17'h00F00;
    step();
    bus.s_x     = 17'h1ABCD;
    step();
    bus.s_valid = 1'b0;
    cfg_wr(2'd3, 17'h00000);
    chk("inflt s_ready drops", bus.s_ready, 1'b0);
    chk("inflt state drain", dbg_state, 2'd1);
    step();
    chk("inflt pulse A", bus.m_valid, 1'b1);
    chk("inflt m_y A", bus.m_y, 17'h00F00 ^ K);
    chk("inflt a1 held A", bus.f_a1, 17'h04000);
    step();
    chk("inflt pulse B", bus.m_valid, 1'b1);
    chk("inflt m_y B", bus.m_y, 17'h1ABCD ^ K);
    chk("inflt a1 held B", bus.f_a1, 17'h04000);
    chk("inflt flt low B", bus.flt_reset, 1'b0);
    step();
    chk("inflt flt high", bus.flt_reset, 1'b1);
    chk("inflt m_valid 0", bus.m_valid, 1'b0);
    chk("inflt a1 new", bus.f_a1, 17'h1FFFF);
    chk("inflt b0 new", bus.f_b0, 17'h10001);
    chk("inflt b1 new", bus.f_b1, 17'h0AAAA);
    step();
    step();
    step();
    chk("inflt flt last", bus.flt_reset, 1'b1);
    chk("inflt s_ready low", bus.s_ready, 1'b0);
    step();
    chk("inflt flt done", bus.flt_reset, 1'b0);
    chk("inflt s_ready back", bus.s_ready, 1'b1);

    // ---------------- sample and commit in the same cycle ----------------
    cfg_wr(2'd0, 17'h00123);
    bus.s_valid   = 1'b1;
    bus.s_x       = 17'h05555;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 2'd3;
    step();
    idle_inputs();
    chk("simul f_x", bus.f_x, 17'h05555);
    chk("simul state drain", dbg_state, 2'd1);
    chk("simul s_ready", bus.s_ready, 1'b0);
    step();
    step();
    chk("simul no early pulse", bus.m_valid, 1'b0);
    step();
    chk("simul pulse", bus.m_valid, 1'b1);
    chk("simul m_y", bus.m_y, 17'h05555 ^ K);
    chk("simul a1 held", bus.f_a1, 17'h1FFFF);
    chk("simul flt low", bus.flt_reset, 1'b0);
    step();
    chk("simul flt high", bus.flt_reset, 1'b1);
    chk("simul a1 new", bus.f_a1, 17'h00123);
    chk("simul b0 kept", bus.f_b0, 17'h10001);
    step();
    step();
    step();
    chk("simul s_ready still low", bus.s_ready, 1'b0);
    step();
    chk("simul s_ready back", bus.s_ready, 1'b1);
    chk("simul state run", dbg_state, 2'd0);

    // ---------------- back-to-back 16 samples ----------------
    pulses  = 0;
    prev_fy = '0;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) begin
        x = 17'(c * 257 + 16);
        bus.s_valid = 1'b1;
        bus.s_x     = x;
        exp_q.push_back(x ^ K);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
      end
      #1;
      if (bus.m_valid) begin
        chk("b2b pulse cycle", 32'(c), 32'(4 + pulses));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b2b extra pulse act=%h exp=none", bus.m_y);
        end else begin
          chk("b2b m_y", bus.m_y, exp_q.pop_front());
        end
        chk("b2b m_y vs f_y", bus.m_y, prev_fy);
        pulses++;
      end
      prev_fy = bus.f_y;
      step();
    end
    chk("b2b pulse count", 32'(pulses), 32'd16);
    chk("b2b queue empty", 32'(exp_q.size()), 32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    bus.s_valid = 1'b1;
    bus.s_x     = 17'h0F0F0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst flt_reset", bus.flt_reset, 1'b1);
    chk("arst f_x", bus.f_x, 17'h0);
    chk("arst m_y", bus.m_y, 17'h0);
    chk("arst m_valid", bus.m_valid, 1'b0);
    chk("arst f_a1", bus.f_a1, 17'h0);
    chk("arst f_b0", bus.f_b0, 17'h0);
    chk("arst s_ready", bus.s_ready, 1'b0);
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst release flt", bus.flt_reset, 1'b0);
    chk("arst release s_ready", bus.s_ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("arst no pulse %0d", c), bus.m_valid, 1'b0);
      step();
    end
    chk("arst a1 after", bus.f_a1, 17'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
